// File: rtl/fpro_pkg.sv
// Shared definitions for the FPro bus arbiter: default bus widths and the FSM state type.
package fpro_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector; a tie goes to whichever requester was not granted last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // Grant index selection
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Two-master arbiter onto a single FPro MMIO bus; one transaction at a time,
// with the winner's request latched at grant so later master-side changes are ignored.
module fpro_bus_arbiter
  import fpro_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              bus_mmio_cs,
  output logic              bus_wr,
  output logic              bus_rd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data
);

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cs_q, cs_d;
  logic                bwr_q, bwr_d;
  logic                brd_q, brd_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                arb_gnt;
  logic                sel_wr;

  rr_arb2 u_rr_arb2 (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .grant (arb_gnt)
  );

  // Strobes and acks are computed one cycle ahead so they are flop outputs aligned with the state
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cs_d    = 1'b0;
    bwr_d   = 1'b0;
    brd_d   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    sel_wr  = arb_gnt ? m1_wr : m0_wr;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = arb_gnt;
          wr_d    = sel_wr;
          addr_d  = arb_gnt ? m1_addr : m0_addr;
          wdata_d = arb_gnt ? m1_wr_data : m0_wr_data;
          cs_d    = 1'b1;
          bwr_d   = sel_wr;
          brd_d   = ~sel_wr;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        rdata_d = bus_rd_data;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset leaves last=m1 so m0 wins the first tie
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      cs_q    <= 1'b0;
      bwr_q   <= 1'b0;
      brd_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      bwr_q   <= bwr_d;
      brd_q   <= brd_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign bus_mmio_cs = cs_q;
  assign bus_wr      = bwr_q;
  assign bus_rd      = brd_q;
  assign bus_addr    = addr_q;
  assign bus_wr_data = wdata_q;
  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign m0_rd_data  = rdata_q;
  assign m1_rd_data  = rdata_q;

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// Self-checking bench for fpro_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fpro_bus_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req = 1'b0, m0_wr = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wr_data = '0;
  logic          m1_req = 1'b0, m1_wr = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wr_data = '0;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          bus_mmio_cs, bus_wr, bus_rd;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;

  int checks = 0;
  int errors = 0;

  // slave model: read data appears the cycle after bus_rd
  bit            use_fixed = 1'b0;
  logic [DW-1:0] fixed_val = '0;
  logic [DW-1:0] slave_q = '0;

  function automatic logic [DW-1:0] slave_fn(input logic [AW-1:0] a);
    return {11'h5A5, a} ^ 32'hC3C3_0F0F;
  endfunction

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus_rd) slave_q <= use_fixed ? fixed_val : slave_fn(bus_addr);
  end
  assign bus_rd_data = slave_q;

  fpro_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .bus_mmio_cs(bus_mmio_cs), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data)
  );

  task automatic drive(input int m, input logic rq, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_req = rq; m0_wr = wr; m0_addr = a; m0_wr_data = d;
    end else begin
      m1_req = rq; m1_wr = wr; m1_addr = a; m1_wr_data = d;
    end
  endtask

  // leaves the bench at a negedge with the DUT idle and out of reset
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b1, 1'b1, 21'h1ABCD, 32'hFFFF_0000);
    drive(1, 1'b1, 1'b0, 21'h0F0F0, 32'h1234_4321);
    repeat (3) begin
      @(negedge clock);
      checks++;
      if ({bus_mmio_cs, bus_wr, bus_rd, m0_ack, m1_ack} !== 5'b00000) begin
        errors++; $display("FAIL reset_strobes got %b want 00000", {bus_mmio_cs, bus_wr, bus_rd, m0_ack, m1_ack});
      end
      checks++;
      if (bus_addr !== 21'h0 || bus_wr_data !== 32'h0 || m0_rd_data !== 32'h0 || m1_rd_data !== 32'h0) begin
        errors++; $display("FAIL reset_values got addr=%h wd=%h rd0=%h rd1=%h want zeros", bus_addr, bus_wr_data, m0_rd_data, m1_rd_data);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
  endtask

  task automatic test_write_m0();
    apply_reset();
    drive(0, 1'b1, 1'b1, 21'h00010, 32'hDEAD_BEEF);
    @(negedge clock);
    checks++;
    if ({bus_mmio_cs, bus_wr, bus_rd} !== 3'b110 || bus_addr !== 21'h00010 || bus_wr_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_issue got cs/wr/rd=%b addr=%h wd=%h want 110 00010 deadbeef", {bus_mmio_cs, bus_wr, bus_rd}, bus_addr, bus_wr_data);
    end
    checks++;
    if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL wr_early_ack got %b want 00", {m0_ack, m1_ack}); end
    @(negedge clock);
    checks++;
    if ({m0_ack, m1_ack} !== 2'b10) begin errors++; $display("FAIL wr_ack got %b want 10", {m0_ack, m1_ack}); end
    checks++;
    if ({bus_mmio_cs, bus_wr, bus_rd} !== 3'b000) begin errors++; $display("FAIL wr_strobe_len got %b want 000", {bus_mmio_cs, bus_wr, bus_rd}); end
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checks++;
    if ({m0_ack, m1_ack} !== 2'b00 || bus_addr !== 21'h00010) begin
      errors++; $display("FAIL wr_after got ack=%b addr=%h want 00 00010", {m0_ack, m1_ack}, bus_addr);
    end
  endtask

  task automatic test_read_m1();
    apply_reset();
    use_fixed = 1'b1; fixed_val = 32'h1234_5678;
    drive(1, 1'b1, 1'b0, 21'h00020, 32'h0);
    @(negedge clock);
    checks++;
    if ({bus_mmio_cs, bus_wr, bus_rd} !== 3'b101 || bus_addr !== 21'h00020) begin
      errors++; $display("FAIL rd_issue got cs/wr/rd=%b addr=%h want 101 00020", {bus_mmio_cs, bus_wr, bus_rd}, bus_addr);
    end
    @(negedge clock);
    checks++;
    if ({m0_ack, m1_ack, bus_mmio_cs, bus_rd} !== 4'b0000) begin
      errors++; $display("FAIL rd_wait got ack/cs/rd=%b want 0000", {m0_ack, m1_ack, bus_mmio_cs, bus_rd});
    end
    @(negedge clock);
    checks++;
    if ({m0_ack, m1_ack} !== 2'b01 || m1_rd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL rd_ack got ack=%b data=%h want 01 12345678", {m0_ack, m1_ack}, m1_rd_data);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    use_fixed = 1'b0;
  endtask

  task automatic test_tie_order();
    int issue_m[$];
    int pend_m, pend_c, acks0, acks1;
    apply_reset();
    pend_m = -1; pend_c = -10; acks0 = 0; acks1 = 0;
    drive(0, 1'b1, 1'b1, 21'h00100, 32'h0000_0001);
    drive(1, 1'b1, 1'b1, 21'h00200, 32'h0000_0002);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      checks++;
      if (m0_ack && m1_ack) begin errors++; $display("FAIL tie_dual_ack cycle %0d both acks high, want at most one", c); end
      if (bus_mmio_cs) begin
        pend_m = (bus_addr == 21'h00200) ? 1 : 0;
        pend_c = c;
        issue_m.push_back(pend_m);
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (c != pend_c + 1 || (m1_ack ? 1 : 0) != pend_m) begin
          errors++; $display("FAIL tie_ack_timing cycle %0d ack=%b want ack for m%0d at cycle %0d", c, {m0_ack, m1_ack}, pend_m, pend_c + 1);
        end
        if (m0_ack) acks0++;
        if (m1_ack) acks1++;
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (issue_m.size() != 4) begin
      errors++; $display("FAIL tie_count got %0d issues want 4", issue_m.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (issue_m[i] != i % 2) begin errors++; $display("FAIL tie_order grant %0d got m%0d want m%0d", i, issue_m[i], i % 2); end
      end
    end
    checks++;
    if (acks0 != 2 || acks1 != 2) begin errors++; $display("FAIL tie_acks got %0d/%0d want 2/2", acks0, acks1); end
  endtask

  task automatic test_addr_change();
    apply_reset();
    drive(0, 1'b1, 1'b0, 21'h00333, 32'h0);
    @(negedge clock);
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 21'h1FFFF, 32'hAAAA_5555);
    checks++;
    if (bus_addr !== 21'h00333) begin errors++; $display("FAIL chg_addr_wait got %h want 00333", bus_addr); end
    @(negedge clock);
    checks++;
    if (m0_ack !== 1'b1 || m0_rd_data !== slave_fn(21'h00333) || bus_addr !== 21'h00333) begin
      errors++; $display("FAIL chg_rd_data got ack=%b data=%h addr=%h want 1 %h 00333", m0_ack, m0_rd_data, bus_addr, slave_fn(21'h00333));
    end
    drive(0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    drive(0, 1'b1, 1'b0, 21'h00444, 32'h0);
    @(negedge clock);
    checks++;
    if (bus_rd !== 1'b1) begin errors++; $display("FAIL rst_wait_issue got rd=%b want 1", bus_rd); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({m0_ack, m1_ack, bus_mmio_cs, bus_wr, bus_rd} !== 5'b00000 || m0_rd_data !== 32'h0) begin
      errors++; $display("FAIL rst_wait_abort got ack/cs/wr/rd=%b rd_data=%h want 00000 0", {m0_ack, m1_ack, bus_mmio_cs, bus_wr, bus_rd}, m0_rd_data);
    end
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    checks++;
    if ({m0_ack, m1_ack, bus_mmio_cs} !== 3'b000) begin
      errors++; $display("FAIL rst_wait_late got ack/cs=%b want 000", {m0_ack, m1_ack, bus_mmio_cs});
    end
    drive(0, 1'b1, 1'b1, 21'h000AA, 32'h0);
    drive(1, 1'b1, 1'b1, 21'h000BB, 32'h0);
    @(negedge clock);
    checks++;
    if (bus_mmio_cs !== 1'b1 || bus_addr !== 21'h000AA) begin
      errors++; $display("FAIL rst_first_tie got cs=%b addr=%h want 1 000AA", bus_mmio_cs, bus_addr);
    end
  endtask

  task automatic test_idle();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checks++;
      if ({bus_mmio_cs, bus_wr, bus_rd} !== 3'b000) begin
        errors++; $display("FAIL idle_strobes cycle %0d got %b want 000", c, {bus_mmio_cs, bus_wr, bus_rd});
      end
    end
  endtask

  // Reference: pending transactions per master; a tie goes to the master not served last
  task automatic test_random();
    bit            pend [2];
    logic          t_wr [2];
    logic [AW-1:0] t_ad [2];
    logic [DW-1:0] t_wd [2];
    int            w;
    int            last_served;
    apply_reset();
    use_fixed = 1'b0;
    last_served = 1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int r = 0; r < 200; r++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 2) != 0) begin
          pend[m] = 1'b1;
          t_wr[m] = 1'($urandom_range(0, 1));
          t_ad[m] = AW'($urandom);
          t_wd[m] = $urandom;
        end
      end
      for (int m = 0; m < 2; m++) drive(m, pend[m], t_wr[m], t_ad[m], t_wd[m]);
      if (!pend[0] && !pend[1]) begin
        @(negedge clock);
        checks++;
        if ({bus_mmio_cs, bus_wr, bus_rd, m0_ack, m1_ack} !== 5'b00000) begin
          errors++; $display("FAIL rnd_idle round %0d got %b want 00000", r, {bus_mmio_cs, bus_wr, bus_rd, m0_ack, m1_ack});
        end
        continue;
      end
      w = (pend[0] && pend[1]) ? 1 - last_served : (pend[1] ? 1 : 0);
      @(negedge clock);
      checks++;
      if ({bus_mmio_cs, bus_wr, bus_rd} !== {1'b1, t_wr[w], ~t_wr[w]} || bus_addr !== t_ad[w] ||
          bus_wr_data !== t_wd[w]) begin
        errors++; $display("FAIL rnd_issue round %0d m%0d got cs/wr/rd=%b addr=%h wd=%h want %b %h %h", r, w,
          {bus_mmio_cs, bus_wr, bus_rd}, bus_addr, bus_wr_data, {1'b1, t_wr[w], ~t_wr[w]}, t_ad[w], t_wd[w]);
      end
      drive(w, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      if (!t_wr[w]) begin
        @(negedge clock);
        checks++;
        if ({m0_ack, m1_ack, bus_mmio_cs} !== 3'b000) begin
          errors++; $display("FAIL rnd_wait round %0d got ack/cs=%b want 000", r, {m0_ack, m1_ack, bus_mmio_cs});
        end
      end
      @(negedge clock);
      checks++;
      if ({m0_ack, m1_ack} !== ((w == 1) ? 2'b01 : 2'b10) || bus_mmio_cs !== 1'b0) begin
        errors++; $display("FAIL rnd_ack round %0d got ack=%b cs=%b want m%0d ack cs=0", r, {m0_ack, m1_ack}, bus_mmio_cs, w);
      end
      if (!t_wr[w]) begin
        checks++;
        if (((w == 1) ? m1_rd_data : m0_rd_data) !== slave_fn(t_ad[w])) begin
          errors++; $display("FAIL rnd_rd_data round %0d got %h want %h", r, (w == 1) ? m1_rd_data : m0_rd_data, slave_fn(t_ad[w]));
        end
      end
      drive(w, 1'b0, 1'b0, '0, '0);
      pend[w] = 1'b0;
      last_served = w;
      @(negedge clock);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_write_m0();
    test_read_m1();
    test_tie_order();
    test_addr_change();
    test_reset_in_wait();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpro_bus_arbiter.md
FPRO_BUS_ARBITER -- requirements
Module: fpro_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, meaning FPro bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning FPro bus data width.
REQ-003 SHALL have port clock, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports m0_req / m1_req, input, 1: master requests a transaction; held high until ack.
REQ-006 SHALL have ports m0_wr / m1_wr, input, 1: 1 = write, 0 = read; valid while req is high.
REQ-007 SHALL have ports m0_addr / m1_addr, input, ADDR_W: transaction address.
REQ-008 SHALL have ports m0_wr_data / m1_wr_data, input, DATA_W: write data.
REQ-009 SHALL have ports m0_ack / m1_ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have ports m0_rd_data / m1_rd_data, output, DATA_W: read data, valid in the ack cycle.
REQ-011 SHALL have port bus_mmio_cs, output, 1: FPro MMIO chip select.
REQ-012 SHALL have port bus_wr, output, 1: FPro write strobe.
REQ-013 SHALL have port bus_rd, output, 1: FPro read strobe.
REQ-014 SHALL have port bus_addr, output, ADDR_W: FPro address.
REQ-015 SHALL have port bus_wr_data, output, DATA_W: FPro write data.
REQ-016 SHALL have port bus_rd_data, input, DATA_W: FPro read data, valid one cycle after bus_rd.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE.
REQ-018 SHALL sample requests only in IDLE; with none pending, it SHALL stay in IDLE.
REQ-019 SHALL, in IDLE with exactly one request, grant that master.
REQ-020 SHALL, in IDLE with both requests, grant the master not granted last (round-robin); after reset, m0 wins the first tie.
REQ-021 SHALL, on grant, latch the winner's wr/addr/wr_data and index, then go to ISSUE; later changes on master inputs SHALL be ignored.
REQ-022 SHALL, in ISSUE, drive bus_mmio_cs=1, bus_addr, bus_wr_data and exactly one of bus_wr/bus_rd high for one cycle.
REQ-023 SHALL go ISSUE->DONE for writes and ISSUE->WAIT for reads.
REQ-024 SHALL, in WAIT, register bus_rd_data into the read-data holding register, then go to DONE.
REQ-025 SHALL, in DONE, pulse ack of the granted master only, update the last-grant pointer, then go to IDLE.
REQ-026 SHALL give a write ack 2 cycles after req is sampled, and a read ack 3 cycles after.
REQ-027 SHALL drive the read-data holding register onto both mX_rd_data outputs; it is meaningful only with ack.
REQ-028 SHALL hold bus_mmio_cs, bus_wr and bus_rd at 0 outside ISSUE; bus_addr and bus_wr_data SHALL hold their last latched values.
REQ-029 SHALL treat a req still high in the cycle after ack as a new transaction, eligible in that IDLE cycle.
REQ-030 SHALL never issue two bus transactions in the same cycle, and never assert both acks together.

Reset
REQ-031 SHALL, while reset==0 at a clock edge, enter IDLE and clear the outputs: ack=0, cs/wr/rd=0, addr/wr_data/rd_data=0, last-grant=m1 so m0 wins the first tie.
REQ-032 SHALL, on reset mid-transaction, abort without an ack; strobes SHALL be low in the next cycle.

Structure
REQ-033 SHALL define the FSM state enum and the default ADDR_W/DATA_W constants in shared package fpro_pkg.
REQ-034 SHALL isolate round-robin selection in sub-module rr_arb2 (inputs req[1:0], last; output grant index), which is combinational.

Verification
REQ-035 Single m0 write, addr=0x00010, data=0xDEADBEEF -> one ISSUE cycle with cs=1, wr=1 and matching bus values; m0_ack 2 cycles after sample; m1_ack stays 0.
REQ-036 Single m1 read, addr=0x00020, slave returns 0x12345678 -> bus_rd one cycle; m1_ack 3 cycles after sample with m1_rd_data=0x12345678.
REQ-037 Both masters request from reset, held high -> grant order m0, m1, m0, m1; each ack exactly once per transaction; no overlap.
REQ-038 m0 changes addr during WAIT -> bus_addr unchanged; read data is from the original address.
REQ-039 reset=0 asserted in the WAIT cycle -> no ack is issued; the FSM is in IDLE with all strobes 0 the next cycle; first post-reset tie goes to m0.
REQ-040 Idle bus for 10 cycles -> cs, wr and rd stay 0 throughout.
